// File: rtl/fir_multi_top.sv
// fir_multi_top: multi-channel decimating FIR filter. All channels share one MAC datapath.
// Coefficients can be loaded at run time. Input and output pass through
// show-ahead FIFOs.
//
// Ports:
//   clock, reset        single clock; synchronous active-low reset
//   x_in_din/wr_en/full input sample stream, channel-interleaved (0..CHANNELS-1)
//   y_out_dout/rd_en/empty
//                       filtered output stream, channel-interleaved
//   coeff_wr_en/addr/din
//                       coefficient write port, accepted only while coeff_ready=1
//   coeff_ready         high while the filter sits in the shift (load) phase
//
// Data flow: S_SHIFT pops words into the per-channel delay lines. After DECIMATION
// whole frames, each channel is run through TAPS MAC cycles. Each result is written
// into the output FIFO as (acc >>> BITS), truncated to DATA_SIZE bits.
module fir_multi_top #(
    parameter int unsigned TAPS       = 32,
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned DECIMATION = 8,
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned BITS       = 10,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [DATA_SIZE-1:0]    x_in_din,
    input  logic                    x_in_wr_en,
    output logic                    x_in_full,
    output logic [DATA_SIZE-1:0]    y_out_dout,
    input  logic                    y_out_rd_en,
    output logic                    y_out_empty,
    input  logic                    coeff_wr_en,
    input  logic [$clog2(TAPS)-1:0] coeff_addr,
    input  logic [DATA_SIZE-1:0]    coeff_din,
    output logic                    coeff_ready
);

    localparam int unsigned TapW = $clog2(TAPS);
    localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned FrW  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned AccW = 2 * DATA_SIZE;

    localparam logic [TapW-1:0] TapLast = TapW'(TAPS - 1);
    localparam logic [ChW-1:0]  ChLast  = ChW'(CHANNELS - 1);
    localparam logic [FrW-1:0]  FrLast  = FrW'(DECIMATION - 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StShift, StMac, StWrite} state_t;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    state_t                       state;
    logic [ChW-1:0]               ch;
    logic [FrW-1:0]               frame;
    logic [TapW-1:0]              tap;
    logic signed [AccW-1:0]       acc;
    logic signed [DATA_SIZE-1:0]  coeff [TAPS];
    logic signed [DATA_SIZE-1:0]  dl    [CHANNELS][TAPS];

    // Input fifo
    logic [DATA_SIZE-1:0] in_mem [FIFO_DEPTH];
    logic [PtrW-1:0]      in_wr_ptr, in_rd_ptr;
    logic [CntW-1:0]      in_count;
    logic                 in_push, in_pop, in_empty;
    logic [DATA_SIZE-1:0] in_dout;

    // Output fifo
    logic [DATA_SIZE-1:0] out_mem [FIFO_DEPTH];
    logic [PtrW-1:0]      out_wr_ptr, out_rd_ptr;
    logic [CntW-1:0]      out_count;
    logic                 out_push, out_pop, out_full;

    logic signed [AccW-1:0] product;
    logic [DATA_SIZE-1:0]   y_value;

    assign x_in_full = (in_count == CntFull);
    assign in_empty  = (in_count == '0);
    // A write on a full fifo is dropped even if a pop frees a slot in the same cycle.
    assign in_push   = x_in_wr_en && !x_in_full;
    assign in_pop    = (state == StShift) && !in_empty;
    assign in_dout   = in_mem[in_rd_ptr];

    assign out_full    = (out_count == CntFull);
    assign y_out_empty = (out_count == '0);
    assign out_push    = (state == StWrite) && !out_full;
    assign out_pop     = y_out_rd_en && !y_out_empty;
    assign y_out_dout  = out_mem[out_rd_ptr];

    always_comb begin
        product = $signed(AccW'(coeff[tap])) * $signed(AccW'(dl[ch][tap]));
        y_value = DATA_SIZE'(acc >>> BITS);
    end

    always_ff @(posedge clock) begin
        if (in_push) in_mem[in_wr_ptr] <= x_in_din;
    end

    always_ff @(posedge clock) begin
        if (out_push) out_mem[out_wr_ptr] <= y_value;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            in_wr_ptr  <= '0;
            in_rd_ptr  <= '0;
            in_count   <= '0;
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else begin
            if (in_push)  in_wr_ptr  <= ptr_inc(in_wr_ptr);
            if (in_pop)   in_rd_ptr  <= ptr_inc(in_rd_ptr);
            if (out_push) out_wr_ptr <= ptr_inc(out_wr_ptr);
            if (out_pop)  out_rd_ptr <= ptr_inc(out_rd_ptr);
            if (in_push && !in_pop)       in_count <= in_count + 1'b1;
            else if (!in_push && in_pop)  in_count <= in_count - 1'b1;
            if (out_push && !out_pop)      out_count <= out_count + 1'b1;
            else if (!out_push && out_pop) out_count <= out_count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= StShift;
            coeff_ready <= 1'b1;
            ch          <= '0;
            frame       <= '0;
            tap         <= '0;
            acc         <= '0;
            for (int i = 0; i < int'(TAPS); i++) coeff[i] <= '0;
            for (int c = 0; c < int'(CHANNELS); c++) begin
                for (int i = 0; i < int'(TAPS); i++) dl[c][i] <= '0;
            end
        end else begin
            unique case (state)
                StShift: begin
                    if (coeff_wr_en) coeff[coeff_addr] <= coeff_din;
                    if (in_pop) begin
                        dl[ch][0] <= in_dout;
                        for (int i = 1; i < int'(TAPS); i++) dl[ch][i] <= dl[ch][i-1];
                        if (ch == ChLast) begin
                            ch <= '0;
                            if (frame == FrLast) begin
                                frame       <= '0;
                                acc         <= '0;
                                tap         <= '0;
                                coeff_ready <= 1'b0;
                                state       <= StMac;
                            end else begin
                                frame <= frame + 1'b1;
                            end
                        end else begin
                            ch <= ch + 1'b1;
                        end
                    end
                end
                StMac: begin
                    acc <= acc + product;
                    if (tap == TapLast) begin
                        tap   <= '0;
                        state <= StWrite;
                    end else begin
                        tap <= tap + 1'b1;
                    end
                end
                StWrite: begin
                    // Stall here while the output fifo is full; acc is held.
                    if (!out_full) begin
                        if (ch == ChLast) begin
                            ch          <= '0;
                            coeff_ready <= 1'b1;
                            state       <= StShift;
                        end else begin
                            ch    <= ch + 1'b1;
                            acc   <= '0;
                            state <= StMac;
                        end
                    end
                end
                default: begin
                    coeff_ready <= 1'b1;
                    state       <= StShift;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_multi_top.sv
// tb_fir_multi_top: directed self-checking bench for fir_multi_top.
// Instance 0 uses DECIMATION=8 and instance 1 uses DECIMATION=1. Both instances
// use TAPS=32, CHANNELS=2, BITS=10 and FIFO_DEPTH=16.
module tb_fir_multi_top;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n [2];
    logic [31:0] x_din   [2];
    logic        x_wr    [2];
    logic        x_full  [2];
    logic [31:0] y_dout  [2];
    logic        y_rd    [2];
    logic        y_empty [2];
    logic        c_wr    [2];
    logic [4:0]  c_addr  [2];
    logic [31:0] c_din   [2];
    logic        c_ready [2];

    int compared   = 0;
    int mismatched = 0;

    fir_multi_top #(
        .TAPS(32), .CHANNELS(2), .DECIMATION(8), .DATA_SIZE(32), .BITS(10), .FIFO_DEPTH(16)
    ) u_dut_dec8 (
        .clock(clock), .reset(reset_n[0]),
        .x_in_din(x_din[0]), .x_in_wr_en(x_wr[0]), .x_in_full(x_full[0]),
        .y_out_dout(y_dout[0]), .y_out_rd_en(y_rd[0]), .y_out_empty(y_empty[0]),
        .coeff_wr_en(c_wr[0]), .coeff_addr(c_addr[0]), .coeff_din(c_din[0]),
        .coeff_ready(c_ready[0])
    );

    fir_multi_top #(
        .TAPS(32), .CHANNELS(2), .DECIMATION(1), .DATA_SIZE(32), .BITS(10), .FIFO_DEPTH(16)
    ) u_dut_dec1 (
        .clock(clock), .reset(reset_n[1]),
        .x_in_din(x_din[1]), .x_in_wr_en(x_wr[1]), .x_in_full(x_full[1]),
        .y_out_dout(y_dout[1]), .y_out_rd_en(y_rd[1]), .y_out_empty(y_empty[1]),
        .coeff_wr_en(c_wr[1]), .coeff_addr(c_addr[1]), .coeff_din(c_din[1]),
        .coeff_ready(c_ready[1])
    );

    // All tasks are entered and left just after a falling edge.
    task automatic do_reset(input int sel);
        reset_n[sel] = 1'b0;
        repeat (2) @(negedge clock);
        reset_n[sel] = 1'b1;
        @(negedge clock);
    endtask

    task automatic push_word(input int sel, input logic signed [31:0] val);
        int waited = 0;
        while (x_full[sel] === 1'b1 && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        if (x_full[sel] === 1'b1) begin
            $display("FAIL push_timeout dut%0d: x_in_full still %b, required 0", sel, x_full[sel]);
            mismatched++;
            compared++;
        end else begin
            x_din[sel] = val;
            x_wr[sel]  = 1'b1;
            @(negedge clock);
            x_wr[sel]  = 1'b0;
        end
    endtask

    task automatic pop_word(input int sel, output logic signed [31:0] val);
        int waited = 0;
        while (y_empty[sel] !== 1'b0 && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        if (y_empty[sel] !== 1'b0) begin
            $display("FAIL pop_timeout dut%0d: y_out_empty still %b, required 0", sel, y_empty[sel]);
            mismatched++;
            compared++;
            val = 32'hDEAD_BEEF;
        end else begin
            val = y_dout[sel];
            y_rd[sel] = 1'b1;
            @(negedge clock);
            y_rd[sel] = 1'b0;
        end
    endtask

    task automatic load_coeff(input int sel, input int addr, input logic signed [31:0] val);
        int waited = 0;
        while (c_ready[sel] !== 1'b1 && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        if (c_ready[sel] !== 1'b1) begin
            $display("FAIL coeff_timeout dut%0d: coeff_ready %b, required 1", sel, c_ready[sel]);
            mismatched++;
            compared++;
        end
        c_addr[sel] = 5'(addr);
        c_din[sel]  = val;
        c_wr[sel]   = 1'b1;
        @(negedge clock);
        c_wr[sel]   = 1'b0;
    endtask

    task automatic wait_mac(input int sel);
        int waited = 0;
        while (c_ready[sel] !== 1'b0 && waited < 2000) begin
            @(negedge clock);
            waited++;
        end
        if (c_ready[sel] !== 1'b0) begin
            $display("FAIL mac_timeout dut%0d: coeff_ready %b, required 0", sel, c_ready[sel]);
            mismatched++;
            compared++;
        end
    endtask

    task automatic test_reset();
        reset_n[0] = 1'b0;
        reset_n[1] = 1'b0;
        repeat (2) @(negedge clock);
        reset_n[0] = 1'b1;
        reset_n[1] = 1'b1;
        @(negedge clock);
        for (int s = 0; s < 2; s++) begin
            if (x_full[s] !== 1'b0) begin
                $display("FAIL reset_x_in_full dut%0d: got %b want 0", s, x_full[s]);
                mismatched++;
            end
            compared++;
            if (y_empty[s] !== 1'b1) begin
                $display("FAIL reset_y_out_empty dut%0d: got %b want 1", s, y_empty[s]);
                mismatched++;
            end
            compared++;
            if (c_ready[s] !== 1'b1) begin
                $display("FAIL reset_coeff_ready dut%0d: got %b want 1", s, c_ready[s]);
                mismatched++;
            end
            compared++;
        end
    endtask

    task automatic test_pass_through();
        logic signed [31:0] got, exp;
        do_reset(0);
        load_coeff(0, 0, 1024);
        for (int n = 1; n <= 16; n++) begin
            push_word(0, n);
            push_word(0, -n);
            if (n <= 7) begin
                if (y_empty[0] !== 1'b1) begin
                    $display("FAIL passthru_early_empty frame %0d: got %b want 1", n, y_empty[0]);
                    mismatched++;
                end
                compared++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            pop_word(0, got);
            exp = (i % 2 == 0) ? 8 * (i / 2 + 1) : -8 * (i / 2 + 1);
            if (got !== exp) begin
                $display("FAIL passthru word %0d: got %0d want %0d", i, got, exp);
                mismatched++;
            end
            compared++;
        end
        repeat (200) @(negedge clock);
        if (y_empty[0] !== 1'b1) begin
            $display("FAIL passthru_no_extra: y_out_empty got %b want 1", y_empty[0]);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_delay();
        logic signed [31:0] got, exp;
        do_reset(1);
        load_coeff(1, 3, 1024);
        push_word(1, 1000);
        push_word(1, 2000);
        for (int f = 2; f <= 6; f++) begin
            push_word(1, 0);
            push_word(1, 0);
        end
        for (int i = 0; i < 12; i++) begin
            pop_word(1, got);
            exp = (i == 6) ? 1000 : (i == 7) ? 2000 : 0;
            if (got !== exp) begin
                $display("FAIL delay word %0d: got %0d want %0d", i, got, exp);
                mismatched++;
            end
            compared++;
        end
    endtask

    task automatic test_dequant();
        logic signed [31:0] got0, got1, exp0, exp1;
        int m;
        do_reset(1);
        for (int a = 0; a < 32; a++) load_coeff(1, a, 512);
        for (int k = 1; k <= 34; k++) begin
            push_word(1, -3);
            push_word(1, 3);
            pop_word(1, got0);
            pop_word(1, got1);
            m    = 1536 * ((k < 32) ? k : 32);
            exp0 = -((m + 1023) / 1024);
            exp1 = m / 1024;
            if (got0 !== exp0 || got1 !== exp1) begin
                $display("FAIL dequant frame %0d: got (%0d,%0d) want (%0d,%0d)",
                         k, got0, got1, exp0, exp1);
                mismatched++;
            end
            compared++;
        end
    endtask

    task automatic test_backpressure();
        logic signed [31:0] got0, got1;
        int pushed = 0;
        int stall  = 0;
        int cycles = 0;
        bit full_seen = 1'b0;
        int f;
        do_reset(0);
        load_coeff(0, 0, 1024);
        load_coeff(0, 1, 2048);
        while (cycles < 4000 && !(full_seen && stall >= 200)) begin
            if (x_full[0] === 1'b1) begin
                full_seen = 1'b1;
                stall++;
                x_wr[0] = 1'b0;
            end else begin
                stall = 0;
                f = pushed / 2 + 1;
                x_din[0] = (pushed % 2 == 0) ? f : -3 * f;
                x_wr[0]  = 1'b1;
                pushed++;
            end
            @(negedge clock);
            cycles++;
        end
        x_wr[0] = 1'b0;
        if (!full_seen) begin
            $display("FAIL backpressure_full: x_in_full never rose, want 1");
            mismatched++;
        end
        compared++;
        if (pushed != 160) begin
            $display("FAIL backpressure_accepted: got %0d words want 160", pushed);
            mismatched++;
        end
        compared++;
        for (int j = 1; j <= 10; j++) begin
            pop_word(0, got0);
            pop_word(0, got1);
            if (got0 !== 24 * j - 2 || got1 !== -72 * j + 6) begin
                $display("FAIL backpressure frame %0d: got (%0d,%0d) want (%0d,%0d)",
                         j, got0, got1, 24 * j - 2, -72 * j + 6);
                mismatched++;
            end
            compared++;
        end
        repeat (100) @(negedge clock);
        if (y_empty[0] !== 1'b1 || x_full[0] !== 1'b0) begin
            $display("FAIL backpressure_drained: empty/full got %b/%b want 1/0",
                     y_empty[0], x_full[0]);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_coeff_lockout();
        logic signed [31:0] got0, got1;
        do_reset(0);
        load_coeff(0, 0, 1024);
        for (int f = 0; f < 8; f++) begin
            push_word(0, 5);
            push_word(0, 7);
        end
        wait_mac(0);
        c_addr[0] = 5'd0;
        c_din[0]  = 3072;
        c_wr[0]   = 1'b1;
        if (c_ready[0] !== 1'b0) begin
            $display("FAIL lockout_ready: coeff_ready got %b want 0", c_ready[0]);
            mismatched++;
        end
        compared++;
        @(negedge clock);
        c_wr[0] = 1'b0;
        pop_word(0, got0);
        pop_word(0, got1);
        if (got0 !== 5 || got1 !== 7) begin
            $display("FAIL lockout_unchanged: got (%0d,%0d) want (5,7)", got0, got1);
            mismatched++;
        end
        compared++;
        load_coeff(0, 0, 3072);
        for (int f = 0; f < 8; f++) begin
            push_word(0, 5);
            push_word(0, 7);
        end
        pop_word(0, got0);
        pop_word(0, got1);
        if (got0 !== 15 || got1 !== 21) begin
            $display("FAIL lockout_shift_write: got (%0d,%0d) want (15,21)", got0, got1);
            mismatched++;
        end
        compared++;
    endtask

    task automatic test_reset_mid_mac();
        logic signed [31:0] got0, got1;
        do_reset(0);
        load_coeff(0, 0, 1024);
        for (int f = 0; f < 10; f++) begin
            push_word(0, 9);
            push_word(0, 4);
        end
        wait_mac(0);
        reset_n[0] = 1'b0;
        @(negedge clock);
        reset_n[0] = 1'b1;
        if (y_empty[0] !== 1'b1 || x_full[0] !== 1'b0 || c_ready[0] !== 1'b1) begin
            $display("FAIL midmac_reset_flags: empty/full/ready got %b/%b/%b want 1/0/1",
                     y_empty[0], x_full[0], c_ready[0]);
            mismatched++;
        end
        compared++;
        repeat (150) @(negedge clock);
        if (y_empty[0] !== 1'b1) begin
            $display("FAIL midmac_no_output: y_out_empty got %b want 1", y_empty[0]);
            mismatched++;
        end
        compared++;
        load_coeff(0, 1, 1024);
        for (int f = 1; f <= 8; f++) begin
            push_word(0, f);
            push_word(0, 2 * f);
        end
        pop_word(0, got0);
        pop_word(0, got1);
        if (got0 !== 7 || got1 !== 14) begin
            $display("FAIL midmac_fresh_run: got (%0d,%0d) want (7,14)", got0, got1);
            mismatched++;
        end
        compared++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            reset_n[s] = 1'b0;
            x_din[s]   = '0;
            x_wr[s]    = 1'b0;
            y_rd[s]    = 1'b0;
            c_wr[s]    = 1'b0;
            c_addr[s]  = '0;
            c_din[s]   = '0;
        end
        @(negedge clock);
        test_reset();
        test_pass_through();
        test_delay();
        test_dequant();
        test_backpressure();
        test_coeff_lockout();
        test_reset_mid_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
